// File: rtl/decode_issue_stage.sv
// Decode/issue stage for the RV64I in-order pipeline.
// Decodes the fetch word, builds sign-extended immediates, selects ALU operands,
// computes branch/jump targets, and stalls on RAW hazards. A PIPE_DEPTH-deep
// scoreboard tracks destinations whose results are not yet in the register file.
// Optional feature macro: DECODE_BYPASS_EN (writeback forwarding; the oldest
// scoreboard entry is then excluded from the hazard check).
module decode_issue_stage #(
  parameter int XLEN       = 64,
  parameter int PIPE_DEPTH = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] DE_NPC,
  input  logic [31:0]     DE_IR,
  input  logic            DE_V,
  output logic            DE_READY,
  output logic [4:0]      RS1_IDX,
  output logic [4:0]      RS2_IDX,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic            FLUSH,
  input  logic            EXE_READY,
  output logic            EXE_V,
  output logic [31:0]     EXE_IR,
  output logic [4:0]      EXE_RD,
  output logic [XLEN-1:0] ALU1,
  output logic [XLEN-1:0] ALU2,
  output logic [XLEN-1:0] IMM,
  output logic [XLEN-1:0] TARGET_ADDRESS,
  output logic [XLEN-1:0] STORE_DATA,
  output logic            ILLEGAL,
  input  logic            WB_V,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode  = DE_IR[6:0];
  assign rd      = DE_IR[11:7];
  assign rs1     = DE_IR[19:15];
  assign rs2     = DE_IR[24:20];
  assign RS1_IDX = rs1;
  assign RS2_IDX = rs2;

  // Immediates, all sign-extended from instruction bit 31
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = XLEN'($signed(DE_IR[31:20]));
  assign imm_s = XLEN'($signed({DE_IR[31:25], DE_IR[11:7]}));
  assign imm_b = XLEN'($signed({DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({DE_IR[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0}));

  // Source operand values, optionally forwarded from writeback
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef DECODE_BYPASS_EN
  // The oldest in-flight result is visible on the WB bus, so it need not stall.
  localparam int CHECK_DEPTH = PIPE_DEPTH - 1;
  assign rs1_val = (WB_V && (WB_RD != 5'd0) && (WB_RD == rs1)) ? WB_DATA : RS1_DATA;
  assign rs2_val = (WB_V && (WB_RD != 5'd0) && (WB_RD == rs2)) ? WB_DATA : RS2_DATA;
`else
  localparam int CHECK_DEPTH = PIPE_DEPTH;
  assign rs1_val = RS1_DATA;
  assign rs2_val = RS2_DATA;
  logic unused_wb;
  assign unused_wb = ^{WB_V, WB_RD, WB_DATA};
`endif

  // Decoded controls and selected operands
  logic            is_illegal;
  logic            use_rs1;
  logic            use_rs2;
  logic            opc_writes;
  logic            writes_rd;
  logic [XLEN-1:0] sel_alu1;
  logic [XLEN-1:0] sel_alu2;
  logic [XLEN-1:0] sel_imm;
  logic [XLEN-1:0] sel_tgt;
  logic [XLEN-1:0] sel_sd;

  // Opcode decode and operand selection; unused outputs stay zero
  always_comb begin
    is_illegal = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    opc_writes = 1'b0;
    sel_alu1   = '0;
    sel_alu2   = '0;
    sel_imm    = '0;
    sel_tgt    = '0;
    sel_sd     = '0;
    unique case (opcode)
      OPC_LOAD: begin
        use_rs1 = 1'b1; opc_writes = 1'b1;
        sel_alu1 = rs1_val; sel_alu2 = imm_i; sel_imm = imm_i;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        sel_alu1 = rs1_val; sel_alu2 = imm_s; sel_imm = imm_s; sel_sd = rs2_val;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        sel_alu1 = rs1_val; sel_alu2 = rs2_val; sel_imm = imm_b;
        sel_tgt  = DE_NPC + imm_b;
      end
      OPC_LUI: begin
        opc_writes = 1'b1;
        sel_alu1 = imm_u; sel_imm = imm_u;
      end
      OPC_AUIPC: begin
        opc_writes = 1'b1;
        sel_alu1 = DE_NPC; sel_alu2 = imm_u; sel_imm = imm_u;
      end
      OPC_JAL: begin
        opc_writes = 1'b1;
        sel_alu1 = DE_NPC; sel_alu2 = XLEN'(4); sel_imm = imm_j;
        sel_tgt  = DE_NPC + imm_j;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; opc_writes = 1'b1;
        sel_alu1 = rs1_val; sel_alu2 = imm_i; sel_imm = imm_i;
        sel_tgt  = (rs1_val + imm_i) & ~XLEN'(1);
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1; opc_writes = 1'b1;
        sel_alu1 = rs1_val; sel_alu2 = imm_i; sel_imm = imm_i;
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; opc_writes = 1'b1;
        sel_alu1 = rs1_val; sel_alu2 = rs2_val;
      end
      default: is_illegal = 1'b1;
    endcase
  end

  assign writes_rd = opc_writes && (rd != 5'd0);

  // Scoreboard of in-flight destinations; entry 0 mirrors the output register
  logic [PIPE_DEPTH-1:0] sb_v_q;
  logic [PIPE_DEPTH-1:0] sb_v_d;
  logic [4:0]            sb_rd_q [PIPE_DEPTH];
  logic [4:0]            sb_rd_d [PIPE_DEPTH];

  // RAW hazard: any checked, valid entry matching a used non-zero source
  logic [PIPE_DEPTH-1:0] hit;
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_hit
      if (gi < CHECK_DEPTH) begin : g_chk
        assign hit[gi] = sb_v_q[gi] &&
                         ((use_rs1 && (rs1 != 5'd0) && (sb_rd_q[gi] == rs1)) ||
                          (use_rs2 && (rs2 != 5'd0) && (sb_rd_q[gi] == rs2)));
      end else begin : g_skip
        assign hit[gi] = 1'b0;
      end
    end
  endgenerate

  logic exe_v_q;
  logic adv;
  logic hazard;
  logic fire;

  assign adv      = EXE_READY || !exe_v_q;
  assign hazard   = |hit;
  assign DE_READY = adv && !hazard && !FLUSH;
  assign fire     = DE_V && DE_READY;

  // Scoreboard next state: shift on advance; a flush kills the entry in EXE
  // so that it never propagates into the older slots.
  always_comb begin
    sb_v_d  = sb_v_q;
    sb_rd_d = sb_rd_q;
    if (adv) begin
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        sb_v_d[i]  = sb_v_q[i-1] && !(FLUSH && (i == 1));
        sb_rd_d[i] = sb_rd_q[i-1];
      end
      sb_v_d[0]  = fire && writes_rd;
      sb_rd_d[0] = rd;
    end else if (FLUSH) begin
      sb_v_d[0] = 1'b0;
    end
  end

  // Scoreboard state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sb_v_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) sb_rd_q[i] <= 5'd0;
    end else begin
      sb_v_q  <= sb_v_d;
      sb_rd_q <= sb_rd_d;
    end
  end

  // Output register next state: a bubble (no fire, illegal, flush) loads zeros
  logic            exe_v_d;
  logic [31:0]     exe_ir_q;
  logic [4:0]      exe_rd_q;
  logic [XLEN-1:0] alu1_q, alu2_q, imm_q, tgt_q, sd_q;
  logic            illegal_q;

  assign exe_v_d = fire && !is_illegal;

  // Output register: loads on advance or flush, otherwise holds
  always_ff @(posedge CLK) begin
    if (RESET) begin
      exe_v_q   <= 1'b0;
      exe_ir_q  <= '0;
      exe_rd_q  <= '0;
      alu1_q    <= '0;
      alu2_q    <= '0;
      imm_q     <= '0;
      tgt_q     <= '0;
      sd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= fire && is_illegal;
      if (adv || FLUSH) begin
        exe_v_q  <= exe_v_d;
        exe_ir_q <= exe_v_d ? DE_IR : 32'd0;
        exe_rd_q <= (exe_v_d && writes_rd) ? rd : 5'd0;
        alu1_q   <= exe_v_d ? sel_alu1 : '0;
        alu2_q   <= exe_v_d ? sel_alu2 : '0;
        imm_q    <= exe_v_d ? sel_imm : '0;
        tgt_q    <= exe_v_d ? sel_tgt : '0;
        sd_q     <= exe_v_d ? sel_sd : '0;
      end
    end
  end

  assign EXE_V          = exe_v_q;
  assign EXE_IR         = exe_ir_q;
  assign EXE_RD         = exe_rd_q;
  assign ALU1           = alu1_q;
  assign ALU2           = alu2_q;
  assign IMM            = imm_q;
  assign TARGET_ADDRESS = tgt_q;
  assign STORE_DATA     = sd_q;
  assign ILLEGAL        = illegal_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: expected EXE transactions are queued
// when an instruction is presented and compared when EXE handshakes.
module tb_decode_issue_stage;
  localparam int XLEN       = 64;
  localparam int PIPE_DEPTH = 3;
`ifdef DECODE_BYPASS_EN
  localparam int RAW_STALL  = 2;
  localparam int HOLD_STALL = 0;
`else
  localparam int RAW_STALL  = 3;
  localparam int HOLD_STALL = 1;
`endif

  logic            CLK = 1'b0;
  logic            RESET;
  logic [XLEN-1:0] DE_NPC;
  logic [31:0]     DE_IR;
  logic            DE_V;
  logic            DE_READY;
  logic [4:0]      RS1_IDX, RS2_IDX;
  logic [XLEN-1:0] RS1_DATA, RS2_DATA;
  logic            FLUSH;
  logic            EXE_READY;
  logic            EXE_V;
  logic [31:0]     EXE_IR;
  logic [4:0]      EXE_RD;
  logic [XLEN-1:0] ALU1, ALU2, IMM, TARGET_ADDRESS, STORE_DATA;
  logic            ILLEGAL;
  logic            WB_V;
  logic [4:0]      WB_RD;
  logic [XLEN-1:0] WB_DATA;

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  rd;
    logic [63:0] alu1, alu2, imm, tgt, sd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  // Register file model: x0 reads zero, others a distinct pattern
  function automatic logic [63:0] rf(input logic [4:0] i);
    return (i == 5'd0) ? 64'd0 : 64'h1111_0000_0000_0000 + 64'(i);
  endfunction

  assign RS1_DATA = rf(RS1_IDX);
  assign RS2_DATA = rf(RS2_IDX);

  decode_issue_stage #(.XLEN(XLEN), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .DE_NPC(DE_NPC), .DE_IR(DE_IR), .DE_V(DE_V),
    .DE_READY(DE_READY), .RS1_IDX(RS1_IDX), .RS2_IDX(RS2_IDX),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .FLUSH(FLUSH),
    .EXE_READY(EXE_READY), .EXE_V(EXE_V), .EXE_IR(EXE_IR), .EXE_RD(EXE_RD),
    .ALU1(ALU1), .ALU2(ALU2), .IMM(IMM), .TARGET_ADDRESS(TARGET_ADDRESS),
    .STORE_DATA(STORE_DATA), .ILLEGAL(ILLEGAL), .WB_V(WB_V), .WB_RD(WB_RD),
    .WB_DATA(WB_DATA)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ir, input logic [4:0] rd,
                              input logic [63:0] a1, input logic [63:0] a2,
                              input logic [63:0] im, input logic [63:0] tg,
                              input logic [63:0] sd);
    exp_t e;
    e.ir = ir; e.rd = rd; e.alu1 = a1; e.alu2 = a2; e.imm = im; e.tgt = tg; e.sd = sd;
    return e;
  endfunction

  // Present an instruction, count cycles DE_READY stays low, then fire it.
  task automatic issue(input logic [63:0] npc, input logic [31:0] ir, output int stalls);
    DE_V = 1'b1; DE_NPC = npc; DE_IR = ir; stalls = 0;
    #1;
    while (!DE_READY && stalls < 20) begin
      @(posedge CLK); #2;
      stalls++;
    end
    @(posedge CLK); #1;
    DE_V = 1'b0; DE_IR = 32'd0;
  endtask

  // Output monitor: pop and compare on every completed EXE handshake
  always @(negedge CLK) begin
    if (!RESET && EXE_V && EXE_READY && !FLUSH) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed EXE_IR=%h expected no transaction", EXE_IR);
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn ir=%h rd=%0d alu1=%h alu2=%h imm=%h tgt=%h sd=%h",
                 EXE_IR, EXE_RD, ALU1, ALU2, IMM, TARGET_ADDRESS, STORE_DATA);
        chk("exe_ir", EXE_IR, e.ir);
        chk("exe_rd", EXE_RD, e.rd);
        chk("alu1", ALU1, e.alu1);
        chk("alu2", ALU2, e.alu2);
        chk("imm", IMM, e.imm);
        chk("target", TARGET_ADDRESS, e.tgt);
        chk("store_data", STORE_DATA, e.sd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [63:0] raw_op;
`ifdef DECODE_BYPASS_EN
    raw_op = 64'd5;
`else
    raw_op = rf(5'd1);
`endif
    // Reset dominates an offered instruction
    RESET = 1'b1; DE_V = 1'b1; DE_IR = 32'h00500093; DE_NPC = 64'h100;
    FLUSH = 1'b0; EXE_READY = 1'b1; WB_V = 1'b0; WB_RD = 5'd0; WB_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_exe_v", EXE_V, 0);
    chk("reset_exe_ir", EXE_IR, 0);
    chk("reset_alu1", ALU1, 0);
    chk("reset_illegal", ILLEGAL, 0);
    RESET = 1'b0; DE_V = 1'b0;
    #1;
    chk("idle_de_ready", DE_READY, 1);

    // ADDI x1,x0,5
    exp_q.push_back(mk(32'h00500093, 5'd1, 64'd0, 64'd5, 64'd5, 64'd0, 64'd0));
    issue(64'h100, 32'h00500093, st);
    chk("addi_stalls", st, 0);
    chk("addi_exe_v", EXE_V, 1);
    chk("addi_exe_rd", EXE_RD, 1);

    // ADD x2,x1,x1: RAW on x1
    WB_V = 1'b1; WB_RD = 5'd1; WB_DATA = 64'd5;
    exp_q.push_back(mk(32'h00108133, 5'd2, raw_op, raw_op, 64'd0, 64'd0, 64'd0));
    issue(64'h104, 32'h00108133, st);
    WB_V = 1'b0;
    chk("raw_stalls", st, RAW_STALL);

    // BEQ x0,x0,-8 at 0x200
    exp_q.push_back(mk(32'hFE000CE3, 5'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1F8, 64'd0));
    issue(64'h200, 32'hFE000CE3, st);
    chk("beq_stalls", st, 0);
    chk("beq_target", TARGET_ADDRESS, 64'h1F8);

    // Back-pressure for 4 cycles with LUI x6,0x80000 waiting
    EXE_READY = 1'b0;
    DE_V = 1'b1; DE_IR = 32'h80000337; DE_NPC = 64'h500;
    exp_q.push_back(mk(32'h80000337, 5'd6, 64'hFFFF_FFFF_8000_0000, 64'd0,
                       64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0));
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hold_de_ready", DE_READY, 0);
      @(posedge CLK); #1;
      chk("hold_exe_ir", EXE_IR, 32'hFE000CE3);
      chk("hold_exe_v", EXE_V, 1);
    end
    EXE_READY = 1'b1;
    #1;
    chk("release_de_ready", DE_READY, 1);
    @(posedge CLK); #1;
    DE_V = 1'b0;
    chk("release_issue", EXE_IR, 32'h80000337);

    // SW x2,-4(x9): x2 kept in the frozen scoreboard
    exp_q.push_back(mk(32'hFE24AE23, 5'd0, rf(5'd9), 64'hFFFF_FFFF_FFFF_FFFC,
                       64'hFFFF_FFFF_FFFF_FFFC, 64'd0, rf(5'd2)));
    issue(64'h504, 32'hFE24AE23, st);
    chk("sw_stalls", st, HOLD_STALL);

    // JAL, JALR, AUIPC, LD back to back with no dependencies
    exp_q.push_back(mk(32'h010000EF, 5'd1, 64'h300, 64'd4, 64'd16, 64'h310, 64'd0));
    issue(64'h300, 32'h010000EF, st);
    chk("jal_stalls", st, 0);
    exp_q.push_back(mk(32'h00238067, 5'd0, rf(5'd7), 64'd2, 64'd2, 64'h1111_0000_0000_0008, 64'd0));
    issue(64'h310, 32'h00238067, st);
    chk("jalr_stalls", st, 0);
    exp_q.push_back(mk(32'h00001517, 5'd10, 64'h400, 64'h1000, 64'h1000, 64'd0, 64'd0));
    issue(64'h400, 32'h00001517, st);
    chk("auipc_stalls", st, 0);
    exp_q.push_back(mk(32'h00863583, 5'd11, rf(5'd12), 64'd8, 64'd8, 64'd0, 64'd0));
    issue(64'h404, 32'h00863583, st);
    chk("ld_stalls", st, 0);

    // Illegal word: pulse, no output, no scoreboard entry for x31
    issue(64'h600, 32'hFFFFFFFF, st);
    chk("illegal_stalls", st, 0);
    chk("illegal_pulse", ILLEGAL, 1);
    chk("illegal_exe_v", EXE_V, 0);
    chk("illegal_exe_ir", EXE_IR, 0);
    exp_q.push_back(mk(32'h01FF82B3, 5'd5, rf(5'd31), rf(5'd31), 64'd0, 64'd0, 64'd0));
    issue(64'h604, 32'h01FF82B3, st);
    chk("post_illegal_stalls", st, 0);
    chk("illegal_cleared", ILLEGAL, 0);

    // ADDI x3 held in EXE, then flushed; ADD x4,x3,x3 must not stall
    issue(64'h700, 32'h00700193, st);
    EXE_READY = 1'b0;
    chk("flush_pre_exe_v", EXE_V, 1);
    chk("flush_pre_exe_rd", EXE_RD, 3);
    FLUSH = 1'b1; DE_V = 1'b1; DE_IR = 32'h00318233; DE_NPC = 64'h704;
    #1;
    chk("flush_de_ready", DE_READY, 0);
    @(posedge CLK); #1;
    FLUSH = 1'b0; EXE_READY = 1'b1;
    chk("flush_exe_v", EXE_V, 0);
    exp_q.push_back(mk(32'h00318233, 5'd4, rf(5'd3), rf(5'd3), 64'd0, 64'd0, 64'd0));
    issue(64'h704, 32'h00318233, st);
    chk("post_flush_stalls", st, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
